// File: rtl/wbufifo_lvl.sv
`default_nettype none
// ============================================================================
// wbufifo_lvl : synchronous codeword FIFO with prefetched output register,
//               exact fill count, full/almost-full and sticky error flags.
// Revision    : 1.0
// ============================================================================
module wbufifo_lvl #(
  parameter int BW                = 36,
  parameter int LGFLEN            = 10,
  parameter int AFULL_LVL         = (1 << LGFLEN) - 4,
  parameter int OPT_WRITE_ON_FULL = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_full,
  output logic              o_afull,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty_n,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_err,
  output logic              o_err_stky
);

  localparam int              c_flen_i = 1 << LGFLEN;
  localparam logic [LGFLEN:0] c_flen   = (LGFLEN+1)'(c_flen_i);
  localparam logic [LGFLEN:0] c_afull  = (LGFLEN+1)'(AFULL_LVL);
  localparam logic [LGFLEN:0] c_one    = (LGFLEN+1)'(1);

  logic [BW-1:0]   mem_q [c_flen_i];
  logic [BW-1:0]   data_q;
  logic [LGFLEN:0] wptr_q, wptr_d;
  logic [LGFLEN:0] rptr_q, rptr_d;
  logic [LGFLEN:0] fill_q, fill_d;
  logic            empty_n_q, empty_n_d;
  logic            full_q, full_d;
  logic            afull_q, afull_d;
  logic            err_stky_q, err_stky_d;

  logic            w_rd_ok;
  logic            w_wr_ok;
  logic            w_ram_nonempty;
  logic            w_load;
  logic            w_err;

  always_comb begin
    w_rd_ok        = i_rd & empty_n_q;
    w_wr_ok        = i_wr & (~full_q | ((OPT_WRITE_ON_FULL != 0) & w_rd_ok));
    // RAM excludes the word already sitting in the output register.
    w_ram_nonempty = (wptr_q != rptr_q);
    w_load         = (~empty_n_q | w_rd_ok) & w_ram_nonempty;
    w_err          = (i_wr & ~w_wr_ok) | (i_rd & ~empty_n_q);

    fill_d = fill_q;
    if (w_wr_ok && !w_rd_ok) begin
      fill_d = fill_q + c_one;
    end else if (!w_wr_ok && w_rd_ok) begin
      fill_d = fill_q - c_one;
    end

    wptr_d     = w_wr_ok ? (wptr_q + c_one) : wptr_q;
    rptr_d     = w_load  ? (rptr_q + c_one) : rptr_q;
    empty_n_d  = (~empty_n_q | w_rd_ok) ? w_ram_nonempty : empty_n_q;
    full_d     = (fill_d == c_flen);
    afull_d    = (fill_d >= c_afull);
    err_stky_d = err_stky_q | w_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      empty_n_q  <= 1'b0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      err_stky_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fill_q     <= fill_d;
      empty_n_q  <= empty_n_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      err_stky_q <= err_stky_d;
    end
  end

  // Storage and prefetch register carry no reset; o_empty_n qualifies o_data.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      mem_q[wptr_q[LGFLEN-1:0]] <= i_data;
    end
    if (w_load) begin
      data_q <= mem_q[rptr_q[LGFLEN-1:0]];
    end
  end

  assign o_data     = data_q;
  assign o_empty_n  = empty_n_q;
  assign o_fill     = fill_q;
  assign o_full     = full_q;
  assign o_afull    = afull_q;
  assign o_err      = w_err;
  assign o_err_stky = err_stky_q;

endmodule
`default_nettype wire

// File: tb/tb_wbufifo_lvl.sv
`default_nettype none
// ============================================================================
// tb_wbufifo_lvl : directed bench for wbufifo_lvl (FLEN=4, AFULL_LVL=3),
//                  instance 0 with write-on-full, instance 1 without.
// Revision       : 1.0
// ============================================================================
module tb_wbufifo_lvl;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr;
  logic [7:0]      din;
  logic            rd;
  logic [1:0]      full, afull, empty_n, err, stky;
  logic [1:0][7:0] data;
  logic [1:0][2:0] fill;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit OPT = (g == 0);

    wbufifo_lvl #(
      .BW(8), .LGFLEN(2), .AFULL_LVL(3), .OPT_WRITE_ON_FULL(OPT ? 1 : 0)
    ) u_dut (
      .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din),
      .o_full(full[g]), .o_afull(afull[g]), .i_rd(rd), .o_data(data[g]),
      .o_empty_n(empty_n[g]), .o_fill(fill[g]), .o_err(err[g]), .o_err_stky(stky[g])
    );

    // Model: queue of every accepted word; mvis says the head is presented.
    logic [7:0] mq[$];
    bit         mvis  = 1'b0;
    bit         mstky = 1'b0;
    bit         rdok, wrok, nvis, merr;
    int         ram;

    always @(posedge clk) begin
      if (rst) begin
        mq.delete();
        mvis  = 1'b0;
        mstky = 1'b0;
      end else begin
        rdok = rd && mvis;
        wrok = wr && (mq.size() < 4 || (OPT && rdok));
        if ((wr && !wrok) || (rd && !mvis)) mstky = 1'b1;
        ram  = mq.size() - (mvis ? 1 : 0);
        nvis = (!mvis || rdok) ? (ram > 0) : mvis;
        if (rdok) void'(mq.pop_front());
        if (wrok) mq.push_back(din);
        mvis = nvis;
      end
    end

    always @(negedge clk) begin
      if (checking) begin
        merr = (wr && !(wr && (mq.size() < 4 || (OPT && rd && mvis)))) || (rd && !mvis);
        chk("fill",    g, 32'(fill[g]),    32'(mq.size()));
        chk("empty_n", g, 32'(empty_n[g]), 32'(mvis));
        chk("full",    g, 32'(full[g]),    32'(mq.size() == 4));
        chk("afull",   g, 32'(afull[g]),   32'(mq.size() >= 3));
        chk("err",     g, 32'(err[g]),     32'(merr));
        chk("stky",    g, 32'(stky[g]),    32'(mstky));
        if (mvis) chk("data", g, 32'(data[g]), 32'(mq[0]));
      end
    end
  end

  task automatic drive(input logic w, input logic [7:0] d, input logic r);
    wr  = w;
    din = d;
    rd  = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] exp3 [4];
    int         nexp;
    int         maxfill;

    rst = 1'b1;
    wr  = 1'b0;
    din = 8'h00;
    rd  = 1'b0;
    tick();
    rst = 1'b0;
    checking = 1'b1;
    chk("rst_fill", 0, 32'(fill[0]), 32'd0);
    chk("rst_empty_n", 1, 32'(empty_n[1]), 32'd0);

    // Single write: fill next cycle, data visible the cycle after.
    drive(1'b1, 8'h11, 1'b0);
    tick();
    chk("s1_fill_c1", 0, 32'(fill[0]), 32'd1);
    chk("s1_empty_c1", 0, 32'(empty_n[0]), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("s1_empty_c2", 0, 32'(empty_n[0]), 32'd1);
    chk("s1_data_c2", 0, 32'(data[0]), 32'h11);

    // Fill to full, then overflow write.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b0);
      tick();
      if (i == 2) begin
        chk("s2_afull3", 0, 32'(afull[0]), 32'd1);
        chk("s2_full3", 0, 32'(full[0]), 32'd0);
      end
    end
    chk("s2_full4", 0, 32'(full[0]), 32'd1);
    chk("s2_fill4", 0, 32'(fill[0]), 32'd4);
    drive(1'b1, 8'hC5, 1'b0);
    chk("s2_err", 0, 32'(err[0]), 32'd1);
    chk("s2_err", 1, 32'(err[1]), 32'd1);
    tick();
    chk("s2_stky", 0, 32'(stky[0]), 32'd1);
    chk("s2_fill", 0, 32'(fill[0]), 32'd4);
    chk("s2_head", 0, 32'(data[0]), 32'hA0);

    // Write and read together while full.
    drive(1'b1, 8'hB4, 1'b1);
    chk("s3_err_wof", 0, 32'(err[0]), 32'd0);
    chk("s3_err_nowof", 1, 32'(err[1]), 32'd1);
    tick();
    chk("s3_fill_wof", 0, 32'(fill[0]), 32'd4);
    chk("s3_fill_nowof", 1, 32'(fill[1]), 32'd3);
    exp3[0] = 8'hA1; exp3[1] = 8'hA2; exp3[2] = 8'hA3; exp3[3] = 8'hB4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      chk("s3_read", 0, 32'(data[0]), 32'(exp3[i]));
      tick();
    end
    chk("s3_empty", 0, 32'(fill[0]), 32'd0);

    // Continuous stream across pointer wrap.
    do_reset();
    nexp    = 0;
    maxfill = 0;
    for (int k = 0; k < 30; k++) begin
      drive(k < 12, 8'(k), empty_n[0]);
      if (rd) begin
        chk("s4_seq", 0, 32'(data[0]), 32'(nexp));
        nexp++;
      end
      tick();
      if (int'(fill[0]) > maxfill) maxfill = int'(fill[0]);
    end
    chk("s4_count", 0, 32'(nexp), 32'd12);
    chk("s4_maxfill", 0, 32'(maxfill <= 2), 32'd1);

    // Read while empty.
    chk("s5_stky_pre", 0, 32'(stky[0]), 32'd0);
    drive(1'b0, 8'h00, 1'b1);
    chk("s5_err", 0, 32'(err[0]), 32'd1);
    tick();
    chk("s5_fill", 0, 32'(fill[0]), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    chk("s5_err_off", 0, 32'(err[0]), 32'd0);
    tick();
    tick();
    chk("s5_stky", 0, 32'(stky[0]), 32'd1);

    // Mid-stream reset, then reuse.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h30 + 8'(i), 1'b0);
      tick();
    end
    chk("s6_afull_pre", 0, 32'(afull[0]), 32'd1);
    do_reset();
    chk("s6_fill", 0, 32'(fill[0]), 32'd0);
    chk("s6_empty_n", 0, 32'(empty_n[0]), 32'd0);
    chk("s6_afull", 0, 32'(afull[0]), 32'd0);
    chk("s6_stky", 0, 32'(stky[0]), 32'd0);
    drive(1'b1, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("s6_data", 0, 32'(data[0]), 32'h5A);
    chk("s6_data", 1, 32'(data[1]), 32'h5A);
    tick();

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
